// File: rtl/counter_rr_scheduler.sv
// counter_rr_scheduler: round-robin sharing of one counter among NUM_REQ requesters
module counter_rr_scheduler #(
    parameter int CNT_WIDTH = 7,
    parameter int NUM_REQ   = 4,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NUM_REQ*CNT_WIDTH-1:0] cnt_val_i,
    output logic [NUM_REQ-1:0]           grant_o,
    output logic [NUM_REQ-1:0]           done_o,
    output logic                         busy_o,
    output logic                         cnt_start_o,
    output logic [CNT_WIDTH-1:0]         cnt_val_o,
    input  logic                         cnt_done_i
);
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
    state_t               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d, owner_q, owner_d, pick;
    logic [CNT_WIDTH-1:0] val_q, val_d, pick_val;
    logic                 found;
    logic [NUM_REQ-1:0]   owner_oh;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            val_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            val_q    <= val_d;
        end
    end
    // first requester at or after rr_ptr, wrapping
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_i[idx]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end
        end
    end
    assign pick_val = cnt_val_i[pick*CNT_WIDTH +: CNT_WIDTH];
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        val_d    = val_q;
        case (state_q)
            IDLE: if (found) begin
                owner_d = pick;
                val_d   = pick_val;
                state_d = (pick_val == '0) ? DONE : START;
            end
            START: state_d = WAIT;
            WAIT:  state_d = cnt_done_i ? DONE : WAIT;
            DONE: begin
                rr_ptr_d = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    assign owner_oh    = NUM_REQ'(1) << owner_q;
    assign busy_o      = state_q != IDLE;
    assign grant_o     = busy_o ? owner_oh : '0;
    assign done_o      = (state_q == DONE) ? owner_oh : '0;
    assign cnt_start_o = state_q == START;
    assign cnt_val_o   = cnt_start_o ? val_q : '0;
endmodule

// File: tb/tb_counter_rr_scheduler.sv
// tb_counter_rr_scheduler: directed tests of arbitration, handshake, zero value and reset
module tb_counter_rr_scheduler;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [3:0]  req_i = '0;
    logic [27:0] cnt_val_i = '0;
    logic [3:0]  grant_o, done_o;
    logic        busy_o, cnt_start_o;
    logic [6:0]  cnt_val_o;
    logic        cnt_done_i = 0;
    logic [17:0] obs;
    int          pass_cnt = 0, total = 0;

    counter_rr_scheduler dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .cnt_val_i(cnt_val_i),
        .grant_o(grant_o), .done_o(done_o), .busy_o(busy_o),
        .cnt_start_o(cnt_start_o), .cnt_val_o(cnt_val_o), .cnt_done_i(cnt_done_i)
    );

    always #5 clk = ~clk;
    assign obs = {grant_o, done_o, busy_o, cnt_start_o, cnt_val_o};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #2;
        rst_n = 1;
    endtask

    task automatic test_reset();
        tick();
        total++;
        if (obs !== 18'h0) $display("FAIL reset_hold: got %h expected %h", obs, 18'h0);
        else pass_cnt++;
        rst_n = 1;
        tick();
        total++;
        if (obs !== 18'h0) $display("FAIL reset_release: got %h expected %h", obs, 18'h0);
        else pass_cnt++;
    endtask

    task automatic test_single();
        req_i = 4'b0001;
        cnt_val_i = {7'd0, 7'd0, 7'd0, 7'd50};
        tick();
        total++;
        if (obs !== {4'b0001, 4'b0000, 1'b1, 1'b1, 7'd50}) $display("FAIL single_start: got %h", obs);
        else pass_cnt++;
        tick();
        tick();
        total++;
        if (obs !== {4'b0001, 4'b0000, 1'b1, 1'b0, 7'd0}) $display("FAIL single_wait: got %h", obs);
        else pass_cnt++;
        cnt_done_i = 1;
        tick();
        cnt_done_i = 0;
        req_i = 4'b0000;
        total++;
        if (obs !== {4'b0001, 4'b0001, 1'b1, 1'b0, 7'd0}) $display("FAIL single_done: got %h", obs);
        else pass_cnt++;
        tick();
        total++;
        if (obs !== 18'h0) $display("FAIL single_idle: got %h", obs);
        else pass_cnt++;
    endtask

    task automatic test_two_simultaneous();
        do_reset();
        req_i = 4'b0011;
        cnt_val_i = {7'd0, 7'd0, 7'd9, 7'd5};
        tick();
        total++;
        if (obs !== {4'b0001, 4'b0000, 1'b1, 1'b1, 7'd5}) $display("FAIL two_first_start: got %h", obs);
        else pass_cnt++;
        tick();
        cnt_done_i = 1;
        tick();
        cnt_done_i = 0;
        total++;
        if (done_o !== 4'b0001) $display("FAIL two_first_done: got %b expected 0001", done_o);
        else pass_cnt++;
        req_i = 4'b0010;
        tick();
        tick();
        total++;
        if (obs !== {4'b0010, 4'b0000, 1'b1, 1'b1, 7'd9}) $display("FAIL two_second_start: got %h", obs);
        else pass_cnt++;
        tick();
        cnt_done_i = 1;
        tick();
        cnt_done_i = 0;
        total++;
        if (done_o !== 4'b0010) $display("FAIL two_second_done: got %b expected 0010", done_o);
        else pass_cnt++;
        req_i = 4'b0011;
        tick();
        tick();
        total++;
        if (grant_o !== 4'b0001) $display("FAIL two_wrap_grant: got %b expected 0001", grant_o);
        else pass_cnt++;
        tick();
        cnt_done_i = 1;
        tick();
        cnt_done_i = 0;
        req_i = 4'b0000;
        tick();
    endtask

    task automatic test_fairness();
        do_reset();
        req_i = 4'b1111;
        cnt_val_i = {7'd4, 7'd3, 7'd2, 7'd1};
        for (int k = 0; k < 8; k++) begin
            logic [3:0] oh;
            logic [6:0] v;
            oh = 4'b0001 << (k % 4);
            v = 7'(k % 4 + 1);
            tick();
            total++;
            if (obs !== {oh, 4'b0000, 1'b1, 1'b1, v}) $display("FAIL fair_start_%0d: got %h expected %h", k, obs, {oh, 4'b0000, 1'b1, 1'b1, v});
            else pass_cnt++;
            tick();
            cnt_done_i = 1;
            tick();
            cnt_done_i = 0;
            total++;
            if (done_o !== oh) $display("FAIL fair_done_%0d: got %b expected %b", k, done_o, oh);
            else pass_cnt++;
            tick();
        end
        req_i = 4'b0000;
        tick();
    endtask

    task automatic test_zero_value();
        req_i = 4'b0100;
        cnt_val_i = {7'd7, 7'd0, 7'd7, 7'd7};
        tick();
        req_i = 4'b0000;
        total++;
        if (obs !== {4'b0100, 4'b0100, 1'b1, 1'b0, 7'd0}) $display("FAIL zero_done: got %h", obs);
        else pass_cnt++;
        tick();
        total++;
        if (obs !== 18'h0) $display("FAIL zero_idle: got %h", obs);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        req_i = 4'b0001;
        cnt_val_i = {7'd0, 7'd0, 7'd0, 7'd50};
        tick();
        tick();
        total++;
        if (obs !== {4'b0001, 4'b0000, 1'b1, 1'b0, 7'd0}) $display("FAIL mid_wait: got %h", obs);
        else pass_cnt++;
        #1;
        rst_n = 0;
        #1;
        total++;
        if (obs !== 18'h0) $display("FAIL mid_async_reset: got %h expected %h", obs, 18'h0);
        else pass_cnt++;
        #1;
        rst_n = 1;
        tick();
        total++;
        if (obs !== {4'b0001, 4'b0000, 1'b1, 1'b1, 7'd50}) $display("FAIL mid_restart: got %h", obs);
        else pass_cnt++;
        tick();
        cnt_done_i = 1;
        tick();
        cnt_done_i = 0;
        req_i = 4'b0000;
        tick();
    endtask

    task automatic test_done_ignored();
        cnt_done_i = 1;
        tick();
        total++;
        if (obs !== 18'h0) $display("FAIL ign_idle: got %h", obs);
        else pass_cnt++;
        req_i = 4'b0010;
        cnt_val_i = {7'd0, 7'd0, 7'd9, 7'd0};
        tick();
        total++;
        if (obs !== {4'b0010, 4'b0000, 1'b1, 1'b1, 7'd9}) $display("FAIL ign_start: got %h", obs);
        else pass_cnt++;
        tick();
        cnt_done_i = 0;
        total++;
        if (obs !== {4'b0010, 4'b0000, 1'b1, 1'b0, 7'd0}) $display("FAIL ign_in_start: got %h", obs);
        else pass_cnt++;
        tick();
        total++;
        if (done_o !== 4'b0000 || busy_o !== 1'b1) $display("FAIL ign_wait_hold: got done %b busy %b", done_o, busy_o);
        else pass_cnt++;
        cnt_done_i = 1;
        tick();
        cnt_done_i = 0;
        req_i = 4'b0000;
        total++;
        if (obs !== {4'b0010, 4'b0010, 1'b1, 1'b0, 7'd0}) $display("FAIL ign_done: got %h", obs);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_simultaneous();
        test_fairness();
        test_zero_value();
        test_reset_mid();
        test_done_ignored();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
